// File: rtl/cs_out_collector.sv
// Output collector for the CS filter: drops warm-up results, buffers valid Y samples in a
// small FIFO and hands them to a consumer over valid/ready, with debug counters.
module cs_out_collector #(
  parameter int unsigned DW     = 10,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WARMUP = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            y_in,
  input  logic                     in_en,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     warm,
  output logic [15:0]              out_cnt,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  // Wide enough to hold WARMUP itself, and at least one bit when WARMUP is 0.
  localparam int unsigned WW = $clog2(WARMUP + 2);

  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   out_cnt_q, out_cnt_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic warm_w, push_req, push, pop;

  assign warm_w    = (wcnt_q == WW'(WARMUP));
  assign pop       = (level_q != '0) && out_ready;
  assign push_req  = warm_w && in_en;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req && ((level_q < LW'(DEPTH)) || pop);

  assign warm      = warm_w;
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign out_cnt   = out_cnt_q;
  assign overflow  = overflow_q;

  always_comb begin
    wcnt_d     = wcnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    out_cnt_d  = out_cnt_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    if (!warm_w && in_en) begin
      wcnt_d = wcnt_q + WW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = y_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      out_cnt_d = out_cnt_q + 16'd1;
    end
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      out_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      out_cnt_q  <= out_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; it is simply not written on reset edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_cs_out_collector.sv
// Scoreboard bench for cs_out_collector: expected samples are queued as they are pushed and
// compared against out_data whenever the consumer takes one.
module tb_cs_out_collector;

  localparam int unsigned DW     = 10;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned WARMUP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] y_in;
  logic          in_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
  logic          warm;
  logic [15:0]   out_cnt;
  logic          overflow;

  cs_out_collector #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .WARMUP(WARMUP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .y_in     (y_in),
    .in_en    (in_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .warm     (warm),
    .out_cnt  (out_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] sb_q[$];
  int unsigned   m_wcnt;
  int unsigned   m_cnt;
  logic          m_ovf;
  logic [DW-1:0] last_pop;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_state();
    check_val("level", 32'(level), 32'(sb_q.size()));
    check_val("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    check_val("warm", 32'(warm), 32'(m_wcnt == WARMUP));
    check_val("out_cnt", 32'(out_cnt), m_cnt & 32'hFFFF);
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock cycle: inputs are driven 1 time unit after the previous edge.
  task automatic cycle(input logic en, input logic [DW-1:0] y, input logic rdy);
    logic pop;
    in_en     = en;
    y_in      = y;
    out_ready = rdy;
    reset     = 1'b1;
    #1;
    pop = (sb_q.size() != 0) && rdy;
    if (pop) begin
      check_val("pop_data", 32'(out_data), 32'(sb_q[0]));
      last_pop = out_data;
      void'(sb_q.pop_front());
      m_cnt++;
    end
    if (en) begin
      if (m_wcnt < WARMUP) m_wcnt++;
      else if (sb_q.size() < DEPTH) sb_q.push_back(y);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_en     = 1'b1;
    out_ready = 1'b1;
    y_in      = 10'h155;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    m_wcnt = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    check_state();
  endtask

  task automatic warmup();
    for (int i = 1; i <= int'(WARMUP); i++) cycle(1'b1, DW'(i), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) cycle(1'b0, '0, 1'b1);
    check_val("drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int pushed;
    logic en;
    reset = 1'b0; in_en = 1'b0; out_ready = 1'b0; y_in = '0;
    void'($urandom(32'h5eed));
    @(posedge clk);
    #1;
    do_reset();

    // Warm-up: warm rises after the 8th edge, 0x009 is the first stored sample.
    warmup();
    check_val("warm_after_8", 32'(warm), 32'd1);
    cycle(1'b1, 10'h009, 1'b0);
    check_val("first_stored", 32'(out_data), 32'h009);
    check_val("level_after_9", 32'(level), 32'd1);
    drain();

    // Streaming with a ready consumer.
    do_reset();
    warmup();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, DW'(10'h100 + i), 1'b1);
      check_val("stream_level_le1", 32'(level <= 4'd1), 32'd1);
    end
    drain();
    check_val("stream_cnt", 32'(out_cnt), 32'd20);
    check_val("stream_ovf", 32'(overflow), 32'd0);

    // Fill past capacity.
    do_reset();
    warmup();
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(10'h200 + i), 1'b0);
    check_val("fill_level", 32'(level), 32'd8);
    check_val("fill_ovf", 32'(overflow), 32'd1);
    drain();
    check_val("fill_last", 32'(last_pop), 32'h207);

    // Full with simultaneous push and pop.
    do_reset();
    warmup();
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(10'h010 + i), 1'b0);
    cycle(1'b1, 10'h3FF, 1'b1);
    check_val("full_pp_level", 32'(level), 32'd8);
    check_val("full_pp_ovf", 32'(overflow), 32'd0);
    drain();
    check_val("full_pp_last", 32'(last_pop), 32'h3FF);

    // Mid-operation reset at level 5, out_cnt 37.
    do_reset();
    warmup();
    for (int i = 0; i < 38; i++) cycle(1'b1, DW'(10'h040 + i), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(10'h0A0 + i), 1'b0);
    check_val("mid_level", 32'(level), 32'd5);
    check_val("mid_cnt", 32'(out_cnt), 32'd37);
    do_reset();
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_cnt", 32'(out_cnt), 32'd0);
    check_val("rst_warm", 32'(warm), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(10'h0C0 + i), 1'b0);
    check_val("rewarm_level", 32'(level), 32'd0);
    cycle(1'b1, 10'h0D5, 1'b0);
    check_val("rewarm_first", 32'(out_data), 32'h0D5);
    drain();

    // Pointer wrap with random gaps and backpressure.
    do_reset();
    warmup();
    pushed = 0;
    for (int i = 0; i < 400 && pushed < int'(3 * DEPTH + 3); i++) begin
      en = ($urandom_range(0, 3) != 0);
      if (en && sb_q.size() < DEPTH) pushed++;
      else en = 1'b0;
      cycle(en, DW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
    end
    check_val("wrap_pushed", 32'(pushed), 32'(3 * DEPTH + 3));
    drain();
    check_val("wrap_cnt", 32'(out_cnt), 32'(3 * DEPTH + 3));
    check_val("wrap_ovf", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
